// File: rtl/delay_estimator.sv
// delay_estimator: finds the integer lag between a reference stream and a delayed
// copy of it by brute-force cross-correlation over a captured window. The result
// drives the select input of a downstream variable delay line.
//
// Flow: IDLE -> CAPTURE (WIN sample pairs) -> {MAC (one product per clock) -> CMP}
// for each lag 0..MAX_DELAY-1 -> DONE (one-cycle result pulse) -> IDLE.
//
// Optional build macro ABS_CORR_EN: rank lags by |C(k)| instead of signed C(k), so a
// polarity-inverted signal still locks. peak_out always reports the signed value.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous reset, active-high
//   start     one-cycle request to start an estimate (only honoured while idle)
//   in_valid  ref_in/sig_in sample pair valid this cycle (used only while capturing)
//   ref_in    reference stream, signed N bits
//   sig_in    observed (delayed) stream, signed N bits
//   busy      high from the accepted start until the done cycle inclusive
//   done      one-cycle pulse, lag_out/peak_out hold the new result
//   lag_out   estimated lag, held until the next done
//   peak_out  signed correlation value at lag_out, held until the next done
module delay_estimator #(
   parameter int unsigned N         = 16,
   parameter int unsigned MAX_DELAY = 40,
   parameter int unsigned WIN       = 64,
   parameter int unsigned LW        = $clog2(MAX_DELAY),
   parameter int unsigned ACC_W     = 2 * N + $clog2(WIN)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    in_valid,
   input  logic signed [N-1:0]     ref_in,
   input  logic signed [N-1:0]     sig_in,
   output logic                    busy,
   output logic                    done,
   output logic [LW-1:0]           lag_out,
   output logic signed [ACC_W-1:0] peak_out
);

   localparam int unsigned IW = $clog2(WIN);

   typedef enum logic [2:0] {StIdle, StCapture, StMac, StCmp, StDone} state_e;

   state_e                  state_q, state_d;
   logic [IW-1:0]           c_q, c_d;
   logic [IW-1:0]           n_q, n_d;
   logic [LW-1:0]           k_q, k_d;
   logic [LW-1:0]           best_k_q, best_k_d;
   logic [LW-1:0]           lag_q, lag_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic signed [ACC_W-1:0] best_q, best_d;
   logic signed [ACC_W-1:0] peak_q, peak_d;

   logic signed [N-1:0]     ref_buf [WIN];
   logic signed [N-1:0]     sig_buf [WIN];

   logic [IW-1:0]           r_idx;
   logic signed [2*N-1:0]   prod;
   logic signed [ACC_W-1:0] prod_ext;
   logic                    better;

   // Capture buffers carry no reset: contents are always rewritten before use.
   always_ff @(posedge clk) begin
      if (state_q == StCapture && in_valid) begin
         ref_buf[c_q] <= ref_in;
         sig_buf[c_q] <= sig_in;
      end
   end

   // n >= k always holds in MAC, so the reference index never wraps.
   assign r_idx    = n_q - IW'(k_q);
   assign prod     = sig_buf[n_q] * ref_buf[r_idx];
   assign prod_ext = {{(ACC_W - 2 * N){prod[2*N-1]}}, prod};

`ifdef ABS_CORR_EN
   // One extra bit so |most-negative| is representable.
   logic signed [ACC_W:0] acc_mag, best_mag;
   always_comb begin
      acc_mag  = acc_q[ACC_W-1]  ? -{acc_q[ACC_W-1], acc_q}   : {acc_q[ACC_W-1], acc_q};
      best_mag = best_q[ACC_W-1] ? -{best_q[ACC_W-1], best_q} : {best_q[ACC_W-1], best_q};
      better   = acc_mag > best_mag;
   end
`else
   assign better = acc_q > best_q;
`endif

   always_comb begin
      state_d  = state_q;
      c_d      = c_q;
      n_d      = n_q;
      k_d      = k_q;
      acc_d    = acc_q;
      best_d   = best_q;
      best_k_d = best_k_q;
      lag_d    = lag_q;
      peak_d   = peak_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StCapture;
               c_d     = '0;
            end
         end
         StCapture: begin
            if (in_valid) begin
               c_d = c_q + IW'(1);
               if (c_q == IW'(WIN - 1)) begin
                  state_d = StMac;
                  k_d     = '0;
                  n_d     = '0;
                  acc_d   = '0;
               end
            end
         end
         StMac: begin
            acc_d = acc_q + prod_ext;
            n_d   = n_q + IW'(1);
            if (n_q == IW'(WIN - 1)) state_d = StCmp;
         end
         StCmp: begin
            // Strict compare: ties keep the smaller lag.
            if (k_q == '0 || better) begin
               best_d   = acc_q;
               best_k_d = k_q;
            end
            if (k_q == LW'(MAX_DELAY - 1)) begin
               state_d = StDone;
               lag_d   = best_k_d;
               peak_d  = best_d;
            end else begin
               state_d = StMac;
               k_d     = k_q + LW'(1);
               n_d     = IW'(k_q) + IW'(1);
               acc_d   = '0;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         c_q      <= '0;
         n_q      <= '0;
         k_q      <= '0;
         acc_q    <= '0;
         best_q   <= '0;
         best_k_q <= '0;
         lag_q    <= '0;
         peak_q   <= '0;
      end else begin
         state_q  <= state_d;
         c_q      <= c_d;
         n_q      <= n_d;
         k_q      <= k_d;
         acc_q    <= acc_d;
         best_q   <= best_d;
         best_k_q <= best_k_d;
         lag_q    <= lag_d;
         peak_q   <= peak_d;
      end
   end

   assign busy     = (state_q != StIdle);
   assign done     = (state_q == StDone);
   assign lag_out  = lag_q;
   assign peak_out = peak_q;

endmodule

// File: tb/tb_delay_estimator.sv
// tb_delay_estimator: directed bench for delay_estimator with default parameters.
// Streams come from a 16-bit LFSR scaled to +/-1000; the observed stream is a
// (possibly negated) delayed copy. Expected lags are the planted delays, expected
// peaks come from a direct correlation sum over the samples the bench drove.
module tb_delay_estimator;

   localparam int N         = 16;
   localparam int MAX_DELAY = 40;
   localparam int WIN       = 64;
   localparam int LW        = 6;
   localparam int ACC_W     = 38;
   localparam int LAT       = 1821;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic                    start = 1'b0;
   logic                    in_valid = 1'b0;
   logic signed [N-1:0]     ref_in = '0;
   logic signed [N-1:0]     sig_in = '0;
   logic                    busy;
   logic                    done;
   logic [LW-1:0]           lag_out;
   logic signed [ACC_W-1:0] peak_out;

   int n_vec = 0;
   int n_bad = 0;

   int         seq [WIN+MAX_DELAY];
   int         rbuf [WIN];
   int         sbuf [WIN];
   logic [15:0] lfsr = 16'hACE1;

   delay_estimator dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in_valid (in_valid),
      .ref_in   (ref_in),
      .sig_in   (sig_in),
      .busy     (busy),
      .done     (done),
      .lag_out  (lag_out),
      .peak_out (peak_out)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic next_sample(output int v);
      for (int s = 0; s < 16; s++) lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      v = int'(lfsr % 16'd2001) - 1000;
   endtask

   // taper shrinks reference samples 25..63 so the 25-term max-lag peak dominates.
   task automatic gen_seq(input bit taper);
      int v;
      for (int t = 0; t < WIN + MAX_DELAY; t++) begin
         next_sample(v);
         if (taper && t >= MAX_DELAY + 25) v = v / 33;
         seq[t] = v;
      end
   endtask

   function automatic longint corr(input int k);
      longint s = 0;
      for (int n = k; n < WIN; n++) s += longint'(sbuf[n]) * longint'(rbuf[n-k]);
      return s;
   endfunction

   function automatic longint metric(input longint x);
`ifdef ABS_CORR_EN
      return (x < 0) ? -x : x;
`else
      return x;
`endif
   endfunction

   // Returns with the final sample written by the preceding posedge.
   task automatic capture(input int d, input bit neg, input bit gappy);
      int i;
      int ph;
      int sv;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      i  = 0;
      ph = 0;
      while (i < WIN) begin
         in_valid = gappy ? (ph % 3 == 0) : 1'b1;
         if (in_valid) begin
            sv      = neg ? -seq[i+MAX_DELAY-d] : seq[i+MAX_DELAY-d];
            rbuf[i] = seq[i+MAX_DELAY];
            sbuf[i] = sv;
            ref_in  = N'(seq[i+MAX_DELAY]);
            sig_in  = N'(sv);
            i++;
         end else begin
            ref_in = 16'sh5A5A;
            sig_in = -16'sh2B2B;
         end
         ph++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      ref_in   = '0;
      sig_in   = '0;
   endtask

   // lat counts cycles after the final-capture edge (first cycle = 1).
   task automatic wait_done(input int mid_start, input bit done_start, output int lat,
                            output logic [LW-1:0] lag, output logic signed [ACC_W-1:0] pk);
      lat = 1;
      while (!done && lat < 3000) begin
         start = (lat == mid_start);
         @(negedge clk);
         lat++;
      end
      lag = lag_out;
      pk  = peak_out;
      start = done_start;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
      n_vec++; if (lag_out !== '0) begin n_bad++; $display("FAIL reset_lag: got %0d want 0", lag_out); end
      n_vec++; if (peak_out !== '0) begin n_bad++; $display("FAIL reset_peak: got %0d want 0", peak_out); end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_lag7();
      int lat;
      logic [LW-1:0] lag;
      logic signed [ACC_W-1:0] pk, exp_pk;
      longint e = 0;
      gen_seq(1'b0);
      capture(7, 1'b0, 1'b0);
      n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL lag7_busy: got %b want 1", busy); end
      wait_done(0, 1'b0, lat, lag, pk);
      for (int i = 0; i <= WIN - 1 - 7; i++) e += longint'(rbuf[i]) * longint'(rbuf[i]);
      exp_pk = e[ACC_W-1:0];
      n_vec++; if (lat !== LAT) begin n_bad++; $display("FAIL lag7_latency: got %0d want %0d", lat, LAT); end
      n_vec++; if (lag !== 6'd7) begin n_bad++; $display("FAIL lag7_lag: got %0d want 7", lag); end
      n_vec++; if (pk !== exp_pk) begin n_bad++; $display("FAIL lag7_peak: got %0d want %0d", pk, exp_pk); end
      n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL lag7_busy_after: got %b want 0", busy); end
   endtask

   task automatic test_lag_bounds();
      int lat;
      logic [LW-1:0] lag;
      logic signed [ACC_W-1:0] pk, exp_pk;
      longint e;
      gen_seq(1'b0);
      capture(0, 1'b0, 1'b0);
      wait_done(0, 1'b0, lat, lag, pk);
      e = corr(0);
      exp_pk = e[ACC_W-1:0];
      n_vec++; if (lag !== 6'd0) begin n_bad++; $display("FAIL lag0_lag: got %0d want 0", lag); end
      n_vec++; if (pk !== exp_pk) begin n_bad++; $display("FAIL lag0_peak: got %0d want %0d", pk, exp_pk); end
      gen_seq(1'b1);
      capture(39, 1'b0, 1'b0);
      wait_done(0, 1'b0, lat, lag, pk);
      e = corr(39);
      exp_pk = e[ACC_W-1:0];
      n_vec++; if (lag !== 6'd39) begin n_bad++; $display("FAIL lag39_lag: got %0d want 39", lag); end
      n_vec++; if (pk !== exp_pk) begin n_bad++; $display("FAIL lag39_peak: got %0d want %0d", pk, exp_pk); end
   endtask

   task automatic test_gappy_capture();
      int lat;
      logic [LW-1:0] lag;
      logic signed [ACC_W-1:0] pk, exp_pk;
      longint e;
      gen_seq(1'b0);
      capture(12, 1'b0, 1'b1);
      wait_done(0, 1'b0, lat, lag, pk);
      e = corr(12);
      exp_pk = e[ACC_W-1:0];
      n_vec++; if (lat !== LAT) begin n_bad++; $display("FAIL gap_latency: got %0d want %0d", lat, LAT); end
      n_vec++; if (lag !== 6'd12) begin n_bad++; $display("FAIL gap_lag: got %0d want 12", lag); end
      n_vec++; if (pk !== exp_pk) begin n_bad++; $display("FAIL gap_peak: got %0d want %0d", pk, exp_pk); end
   endtask

   task automatic test_start_ignored();
      int lat;
      int extra = 0;
      int busy_seen = 0;
      logic [LW-1:0] lag;
      logic signed [ACC_W-1:0] pk;
      gen_seq(1'b0);
      capture(20, 1'b0, 1'b0);
      wait_done(300, 1'b1, lat, lag, pk);
      n_vec++; if (lat !== LAT) begin n_bad++; $display("FAIL ign_latency: got %0d want %0d", lat, LAT); end
      n_vec++; if (lag !== 6'd20) begin n_bad++; $display("FAIL ign_lag: got %0d want 20", lag); end
      repeat (2100) begin
         if (done) extra++;
         if (busy) busy_seen++;
         @(negedge clk);
      end
      n_vec++; if (extra !== 0) begin n_bad++; $display("FAIL ign_extra_done: got %0d want 0", extra); end
      n_vec++; if (busy_seen !== 0) begin n_bad++; $display("FAIL ign_busy: got %0d want 0", busy_seen); end
      n_vec++; if (lag_out !== 6'd20) begin n_bad++; $display("FAIL ign_hold: got %0d want 20", lag_out); end
      gen_seq(1'b0);
      capture(3, 1'b0, 1'b0);
      wait_done(0, 1'b0, lat, lag, pk);
      n_vec++; if (lag !== 6'd3) begin n_bad++; $display("FAIL rerun_lag: got %0d want 3", lag); end
   endtask

   task automatic test_reset_mid();
      int lat;
      int dones = 0;
      logic [LW-1:0] lag;
      logic signed [ACC_W-1:0] pk;
      gen_seq(1'b0);
      capture(9, 1'b0, 1'b0);
      repeat (500) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_vec++; if (lag_out !== '0) begin n_bad++; $display("FAIL rst_lag: got %0d want 0", lag_out); end
      n_vec++; if (peak_out !== '0) begin n_bad++; $display("FAIL rst_peak: got %0d want 0", peak_out); end
      rst = 1'b0;
      repeat (2000) begin
         if (done) dones++;
         @(negedge clk);
      end
      n_vec++; if (dones !== 0) begin n_bad++; $display("FAIL rst_no_done: got %0d want 0", dones); end
      capture(9, 1'b0, 1'b0);
      wait_done(0, 1'b0, lat, lag, pk);
      n_vec++; if (lag !== 6'd9) begin n_bad++; $display("FAIL rst_rerun_lag: got %0d want 9", lag); end
   endtask

   task automatic test_polarity();
      int lat;
      int bk = 0;
      longint bv = 0;
      longint c;
      logic [LW-1:0] lag;
      logic signed [ACC_W-1:0] pk, exp_pk;
      gen_seq(1'b0);
      capture(5, 1'b1, 1'b0);
      wait_done(0, 1'b0, lat, lag, pk);
      for (int k = 0; k < MAX_DELAY; k++) begin
         c = corr(k);
         if (k == 0 || metric(c) > metric(bv)) begin
            bv = c;
            bk = k;
         end
      end
      exp_pk = bv[ACC_W-1:0];
`ifdef ABS_CORR_EN
      n_vec++; if (lag !== 6'd5) begin n_bad++; $display("FAIL pol_lag: got %0d want 5", lag); end
      n_vec++; if (!(pk < 0)) begin n_bad++; $display("FAIL pol_sign: got %0d want negative", pk); end
`else
      n_vec++; if (lag === 6'd5) begin n_bad++; $display("FAIL pol_lag: got %0d want not 5", lag); end
      n_vec++; if (lag !== LW'(bk)) begin n_bad++; $display("FAIL pol_argmax: got %0d want %0d", lag, bk); end
`endif
      n_vec++; if (pk !== exp_pk) begin n_bad++; $display("FAIL pol_peak: got %0d want %0d", pk, exp_pk); end
   endtask

   initial begin
      test_reset();
      test_lag7();
      test_lag_bounds();
      test_gappy_capture();
      test_start_ignored();
      test_reset_mid();
      test_polarity();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
